// File: rtl/hazard_ctrl_if.sv
// Hazard interface between the ID/EX pipeline stages and the hazard control unit.
// The pipeline side is the master; hazard_ctrl consumes it through the slave modport.
interface hazard_ctrl_if;
  logic [4:0] id_rs1_addr;
  logic [4:0] id_rs2_addr;
  logic       ex_load;
  logic       ex_pcsrc;
  logic [4:0] ex_rd_addr;
  logic       stall;
  logic       flush;

  modport master (
    output id_rs1_addr, id_rs2_addr, ex_load, ex_pcsrc, ex_rd_addr,
    input  stall, flush
  );

  modport slave (
    input  id_rs1_addr, id_rs2_addr, ex_load, ex_pcsrc, ex_rd_addr,
    output stall, flush
  );
endinterface

// File: rtl/hazard_ctrl.sv
// Hazard control unit: load-use stall and branch flush sequencing for the 5-stage pipeline.
// Optional saturating performance counters are enabled by defining HAZARD_PERF_EN.
module hazard_ctrl #(
  parameter int unsigned LOAD_USE_STALL = 1,
  parameter int unsigned FLUSH_CYCLES   = 1,
  parameter int unsigned PERF_W         = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  hazard_ctrl_if.slave      hz,
  output logic              busy,
  output logic [PERF_W-1:0] perf_stall_cnt,
  output logic [PERF_W-1:0] perf_flush_cnt
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    STALL = 2'd1,
    FLUSH = 2'd2
  } state_t;

  localparam logic [3:0] STALL_RELOAD = 4'(LOAD_USE_STALL - 1);
  localparam logic [3:0] FLUSH_RELOAD = 4'(FLUSH_CYCLES - 1);

  state_t     state_r;
  state_t     state_nxt_s;
  logic [3:0] cnt_r;
  logic [3:0] cnt_nxt_s;
  logic       lu_s;
  logic       stall_s;
  logic       flush_s;

  // x0 is hard-wired zero, so a load targeting it never creates a dependency
  assign lu_s = hz.ex_load && (hz.ex_rd_addr != 5'd0) &&
                ((hz.ex_rd_addr == hz.id_rs1_addr) || (hz.ex_rd_addr == hz.id_rs2_addr));

  // Next-state, counter and raw stall/flush decode
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    stall_s     = 1'b0;
    flush_s     = 1'b0;
    case (state_r)
      IDLE, STALL: begin
        // A redirect squashes ID, so it beats both a new hazard and a running stall
        if (hz.ex_pcsrc) begin
          flush_s = 1'b1;
          if (FLUSH_CYCLES > 1) begin
            state_nxt_s = FLUSH;
            cnt_nxt_s   = FLUSH_RELOAD;
          end else begin
            state_nxt_s = IDLE;
            cnt_nxt_s   = 4'd0;
          end
        end else if (state_r == STALL) begin
          stall_s = 1'b1;
          if (cnt_r == 4'd1) begin
            state_nxt_s = IDLE;
            cnt_nxt_s   = 4'd0;
          end else begin
            cnt_nxt_s = cnt_r - 4'd1;
          end
        end else if (lu_s) begin
          stall_s = 1'b1;
          if (LOAD_USE_STALL > 1) begin
            state_nxt_s = STALL;
            cnt_nxt_s   = STALL_RELOAD;
          end else begin
            state_nxt_s = IDLE;
          end
        end else begin
          state_nxt_s = IDLE;
        end
      end
      FLUSH: begin
        flush_s = 1'b1;
        if (hz.ex_pcsrc) begin
          cnt_nxt_s = FLUSH_RELOAD;
        end else if (cnt_r == 4'd1) begin
          state_nxt_s = IDLE;
          cnt_nxt_s   = 4'd0;
        end else begin
          cnt_nxt_s = cnt_r - 4'd1;
        end
      end
      default: begin
        state_nxt_s = IDLE;
        cnt_nxt_s   = 4'd0;
      end
    endcase
  end

  // State and counter registers with synchronous reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= IDLE;
      cnt_r   <= 4'd0;
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
    end
  end

  assign hz.stall = rst_n && stall_s;
  assign hz.flush = rst_n && flush_s;
  assign busy     = (state_r != IDLE);

`ifdef HAZARD_PERF_EN
  logic [PERF_W-1:0] perf_stall_r;
  logic [PERF_W-1:0] perf_flush_r;

  // Saturating counts of stall and flush cycles
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      perf_stall_r <= {PERF_W{1'b0}};
      perf_flush_r <= {PERF_W{1'b0}};
    end else begin
      if (hz.stall && (perf_stall_r != {PERF_W{1'b1}})) begin
        perf_stall_r <= perf_stall_r + PERF_W'(1);
      end
      if (hz.flush && (perf_flush_r != {PERF_W{1'b1}})) begin
        perf_flush_r <= perf_flush_r + PERF_W'(1);
      end
    end
  end

  assign perf_stall_cnt = perf_stall_r;
  assign perf_flush_cnt = perf_flush_r;
`else
  assign perf_stall_cnt = {PERF_W{1'b0}};
  assign perf_flush_cnt = {PERF_W{1'b0}};
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed self-checking bench for hazard_ctrl: default instance (a) and a
// LOAD_USE_STALL=3 / FLUSH_CYCLES=2 / PERF_W=4 instance (b).
module tb_hazard_ctrl;
  logic        clk;
  logic        rst_n;
  logic        busy_a;
  logic        busy_b;
  logic [31:0] perf_stall_a;
  logic [31:0] perf_flush_a;
  logic [3:0]  perf_stall_b;
  logic [3:0]  perf_flush_b;
  int          n_checks;
  int          n_fail;

  hazard_ctrl_if ifa ();
  hazard_ctrl_if ifb ();

  hazard_ctrl u_dut_a (
    .clk            (clk),
    .rst_n          (rst_n),
    .hz             (ifa.slave),
    .busy           (busy_a),
    .perf_stall_cnt (perf_stall_a),
    .perf_flush_cnt (perf_flush_a)
  );

  hazard_ctrl #(
    .LOAD_USE_STALL (3),
    .FLUSH_CYCLES   (2),
    .PERF_W         (4)
  ) u_dut_b (
    .clk            (clk),
    .rst_n          (rst_n),
    .hz             (ifb.slave),
    .busy           (busy_b),
    .perf_stall_cnt (perf_stall_b),
    .perf_flush_cnt (perf_flush_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    ifa.id_rs1_addr = 5'd0; ifa.id_rs2_addr = 5'd0; ifa.ex_load = 1'b0;
    ifa.ex_pcsrc    = 1'b0; ifa.ex_rd_addr  = 5'd0;
    ifb.id_rs1_addr = 5'd0; ifb.id_rs2_addr = 5'd0; ifb.ex_load = 1'b0;
    ifb.ex_pcsrc    = 1'b0; ifb.ex_rd_addr  = 5'd0;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    clear_inputs();
    next_cycle();
    next_cycle();
    @(negedge clk);
    check_eq("rst_stall_a", 32'(ifa.stall), 32'd0);
    check_eq("rst_flush_b", 32'(ifb.flush), 32'd0);
    check_eq("rst_busy_b", 32'(busy_b), 32'd0);
    next_cycle();
    rst_n = 1'b1;

    // Load-use on rs1, default instance: one stall cycle, never busy
    ifa.ex_load = 1'b1; ifa.ex_rd_addr = 5'd5; ifa.id_rs1_addr = 5'd5;
    @(negedge clk);
    check_eq("lu_rs1_stall", 32'(ifa.stall), 32'd1);
    check_eq("lu_rs1_flush", 32'(ifa.flush), 32'd0);
    check_eq("lu_rs1_busy", 32'(busy_a), 32'd0);
    next_cycle();
    ifa.ex_load = 1'b0;
    @(negedge clk);
    check_eq("lu_rs1_end", 32'(ifa.stall), 32'd0);
    check_eq("lu_rs1_busy2", 32'(busy_a), 32'd0);

    // x0 and no-match cases
    next_cycle();
    ifa.ex_load = 1'b1; ifa.ex_rd_addr = 5'd0; ifa.id_rs1_addr = 5'd0;
    @(negedge clk);
    check_eq("x0_stall", 32'(ifa.stall), 32'd0);
    next_cycle();
    ifa.ex_rd_addr = 5'd4; ifa.id_rs1_addr = 5'd3; ifa.id_rs2_addr = 5'd6;
    @(negedge clk);
    check_eq("nomatch_stall", 32'(ifa.stall), 32'd0);

    // Load-use and redirect together: flush wins
    next_cycle();
    ifa.ex_rd_addr = 5'd2; ifa.id_rs1_addr = 5'd2; ifa.ex_pcsrc = 1'b1;
    @(negedge clk);
    check_eq("simul_flush", 32'(ifa.flush), 32'd1);
    check_eq("simul_stall", 32'(ifa.stall), 32'd0);
    next_cycle();
    clear_inputs();
    @(negedge clk);
    check_eq("simul_flush_end", 32'(ifa.flush), 32'd0);
    check_eq("simul_busy", 32'(busy_a), 32'd0);

    // LOAD_USE_STALL=3 on rs2
    next_cycle();
    ifb.ex_load = 1'b1; ifb.ex_rd_addr = 5'd7; ifb.id_rs2_addr = 5'd7;
    @(negedge clk);
    check_eq("lu3_c1_stall", 32'(ifb.stall), 32'd1);
    check_eq("lu3_c1_busy", 32'(busy_b), 32'd0);
    next_cycle();
    ifb.ex_load = 1'b0;
    for (int i = 2; i <= 3; i++) begin
      @(negedge clk);
      check_eq($sformatf("lu3_c%0d_stall", i), 32'(ifb.stall), 32'd1);
      check_eq($sformatf("lu3_c%0d_busy", i), 32'(busy_b), 32'd1);
      next_cycle();
    end
    @(negedge clk);
    check_eq("lu3_c4_stall", 32'(ifb.stall), 32'd0);
    check_eq("lu3_c4_busy", 32'(busy_b), 32'd0);

    // Redirect during STALL aborts the stall
    next_cycle();
    ifb.ex_load = 1'b1;
    next_cycle();
    ifb.ex_load = 1'b0; ifb.ex_pcsrc = 1'b1;
    @(negedge clk);
    check_eq("abort_stall", 32'(ifb.stall), 32'd0);
    check_eq("abort_flush", 32'(ifb.flush), 32'd1);
    next_cycle();
    ifb.ex_pcsrc = 1'b0;
    @(negedge clk);
    check_eq("abort_flush2", 32'(ifb.flush), 32'd1);
    check_eq("abort_stall2", 32'(ifb.stall), 32'd0);
    next_cycle();
    @(negedge clk);
    check_eq("abort_idle", 32'(busy_b), 32'd0);

    // FLUSH_CYCLES=2 with re-trigger at t1
    next_cycle();
    clear_inputs();
    ifb.ex_pcsrc = 1'b1;
    @(negedge clk);
    check_eq("fl_t0", 32'(ifb.flush), 32'd1);
    next_cycle();
    @(negedge clk);
    check_eq("fl_t1", 32'(ifb.flush), 32'd1);
    check_eq("fl_t1_busy", 32'(busy_b), 32'd1);
    next_cycle();
    ifb.ex_pcsrc = 1'b0;
    @(negedge clk);
    check_eq("fl_t2", 32'(ifb.flush), 32'd1);
    next_cycle();
    @(negedge clk);
    check_eq("fl_t3", 32'(ifb.flush), 32'd0);
    check_eq("fl_t3_busy", 32'(busy_b), 32'd0);

    // Reset in the middle of FLUSH
    next_cycle();
    ifb.ex_pcsrc = 1'b1;
    next_cycle();
    ifb.ex_pcsrc = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    check_eq("rstfl_flush", 32'(ifb.flush), 32'd0);
    next_cycle();
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("rstfl_busy", 32'(busy_b), 32'd0);
    check_eq("rstfl_flush2", 32'(ifb.flush), 32'd0);

`ifdef HAZARD_PERF_EN
    // Back-to-back hazards keep stall asserted; 4-bit counter saturates at 15
    check_eq("perf_rst_stall", 32'(perf_stall_b), 32'd0);
    check_eq("perf_rst_flush", 32'(perf_flush_b), 32'd0);
    next_cycle();
    ifb.ex_load = 1'b1; ifb.ex_rd_addr = 5'd7; ifb.id_rs2_addr = 5'd7;
    repeat (10) @(posedge clk);
    #1;
    @(negedge clk);
    check_eq("perf_stall_10", 32'(perf_stall_b), 32'd10);
    check_eq("perf_continuous", 32'(ifb.stall), 32'd1);
    repeat (10) @(posedge clk);
    #1;
    clear_inputs();
    @(negedge clk);
    check_eq("perf_stall_sat", 32'(perf_stall_b), 32'd15);
    check_eq("perf_flush_b", 32'(perf_flush_b), 32'd0);
    check_eq("perf_flush_a", perf_flush_a, 32'd1);
    rst_n = 1'b0;
    next_cycle();
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("perf_clr", 32'(perf_stall_b), 32'd0);
`else
    check_eq("perf_off_stall_a", perf_stall_a, 32'd0);
    check_eq("perf_off_flush_a", perf_flush_a, 32'd0);
    check_eq("perf_off_stall_b", 32'(perf_stall_b), 32'd0);
    check_eq("perf_off_flush_b", 32'(perf_flush_b), 32'd0);
`endif

    next_cycle();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Hazard control unit for the 5-stage pipeline; it is the consumer end of the hazard interface.
- Takes the ID-stage source addresses and the EX-stage load/branch information, and drives Stall (to IF/ID) and Flush (to IF/ID).
- Sequences multi-cycle load-use stalls and multi-cycle flushes with a small FSM and down-counter, so the core can tolerate slower data memory and deeper fetch.

Parameters:
- LOAD_USE_STALL, 1, bubble cycles per load-use hazard; legal range 1..15.
- FLUSH_CYCLES, 1, cycles Flush is held per taken branch/jump; legal range 1..15.
- PERF_W, 32, width of the performance counters (used only with HAZARD_PERF_EN).

Ports:
- clk  in  1  pipeline clock; all state updates on the rising edge.
- rst_n  in  1  synchronous reset, active-low.
- id_rs1_addr  in  5  rs1 of the instruction in ID.
- id_rs2_addr  in  5  rs2 of the instruction in ID.
- ex_load  in  1  instruction in EX is a load.
- ex_pcsrc  in  1  EX redirects the PC (taken branch or jump).
- ex_rd_addr  in  5  rd of the instruction in EX.
- stall  out  1  hold PC and IF/ID; ID/EX receives a bubble.
- flush  out  1  squash IF/ID (wrong-path instruction).
- busy  out  1  FSM is not in IDLE.
- perf_stall_cnt  out  PERF_W  total cycles with stall=1.
- perf_flush_cnt  out  PERF_W  total cycles with flush=1.

Behaviour:
- Clock and reset: one clock; reset is synchronous, active-low. While rst_n=0, the next edge forces state=IDLE, cnt=0 and perf counters=0.
- Output gating: stall and flush are forced 0 combinationally whenever rst_n=0. busy=0 after reset.
- Hazard detect (combinational):
  - lu = ex_load & (ex_rd_addr != 0) & ((ex_rd_addr == id_rs1_addr) | (ex_rd_addr == id_rs2_addr)).
  - x0 never causes a hazard.
- FSM states: IDLE, STALL, FLUSH. cnt is 4-bit.
- IDLE:
  - If ex_pcsrc: flush=1, stall=0. This applies even if lu=1, because the ID instruction is wrong-path and flush wins. If FLUSH_CYCLES>1, go to FLUSH with cnt=FLUSH_CYCLES-1.
  - Else if lu: stall=1, same cycle. If LOAD_USE_STALL>1, go to STALL with cnt=LOAD_USE_STALL-1.
  - Else stall=flush=0.
- STALL:
  - stall=1 regardless of ID/EX inputs; EX holds a bubble, so ex_load is normally 0.
  - cnt decrements each cycle; at cnt==1 the next state is IDLE.
  - Total stall cycles per hazard = LOAD_USE_STALL exactly.
  - If ex_pcsrc=1 in STALL: abort the stall (stall=0), flush=1, and behave as IDLE-with-pcsrc (enter FLUSH or return to IDLE).
- FLUSH:
  - flush=1, stall=0; cnt decrements and returns to IDLE at cnt==1. Total = FLUSH_CYCLES cycles.
  - A new ex_pcsrc in FLUSH reloads cnt=FLUSH_CYCLES-1, so the flush window restarts.
- Back-to-back: a hazard detected in the IDLE cycle immediately after STALL/FLUSH exit is handled normally, with no dead cycle.
- stall and flush are never 1 simultaneously.

Optional Feature:
- Macro HAZARD_PERF_EN.
- Defined: perf_stall_cnt and perf_flush_cnt increment on each cycle where the corresponding output is 1. They saturate at all-ones and clear on reset.
- Undefined: both ports are present but tied to 0, and no counter flops are inferred.

Test Plan:
- Load-use on rs1, defaults: ex_load=1, ex_rd=5, id_rs1=5 -> stall=1 for exactly 1 cycle, flush=0, busy stays 0.
- LOAD_USE_STALL=3: ex_load=1, ex_rd=7, id_rs2=7, then ex_load=0 -> stall=1 for 3 consecutive cycles, busy=1 in cycles 2-3, then stall=0.
- x0 and no match: ex_load=1, ex_rd=0, id_rs1=0 -> stall=0. ex_rd=4, id_rs1=3, id_rs2=6 -> stall=0.
- Simultaneous events: ex_load=1, ex_rd=2, id_rs1=2, ex_pcsrc=1 -> flush=1, stall=0 in the same cycle.
- FLUSH_CYCLES=2 with re-trigger: pcsrc pulse at t0 -> flush at t0 and t1. A second pcsrc at t1 -> flush continues through t2. Reset (rst_n=0) mid-FLUSH -> flush=0 immediately, IDLE after the edge.
- HAZARD_PERF_EN with PERF_W=4: 20 stall cycles -> perf_stall_cnt saturates at 15. Reset -> 0. Build without the macro -> both counters read 0.
